// File: rtl/atomic_unit_pkg.sv
// rtl/atomic_unit_pkg.sv - shared types for the atomic execute unit
// Contents: decoded instruction type (one-hot), atomic sub-op (one-hot),
// exception codes, atomic FSM states and a word-align helper.
package atomic_unit_pkg;

    typedef enum logic [56:0] {
        NOP         = 57'h1,
        ADD         = 57'h2,
        LOAD_WORD   = 57'h4,
        STORE_WORD  = 57'h8,
        LR_W        = 57'h10,
        SC_W        = 57'h20,
        AMO_W       = 57'h40
    } iType_e;

    typedef enum logic [9:0] {
        AMONOP      = 10'b00_0000_0001,
        AMOSWAP_W   = 10'b00_0000_0010,
        AMOADD_W    = 10'b00_0000_0100,
        AMOXOR_W    = 10'b00_0000_1000,
        AMOAND_W    = 10'b00_0001_0000,
        AMOOR_W     = 10'b00_0010_0000,
        AMOMIN_W    = 10'b00_0100_0000,
        AMOMAX_W    = 10'b00_1000_0000,
        AMOMINU_W   = 10'b01_0000_0000,
        AMOMAXU_W   = 10'b10_0000_0000
    } iTypeAtomic_e;

    typedef enum logic [3:0] {
        INSTRUCTION_ADDRESS_MISALIGNED = 4'd0,
        ILLEGAL_INSTRUCTION            = 4'd2,
        LOAD_ADDRESS_MISALIGNED        = 4'd4,
        STORE_AMO_ADDRESS_MISALIGNED   = 4'd6
    } exceptionCode_e;

    typedef enum logic [1:0] {
        A_IDLE = 2'd0,
        A_LOAD = 2'd1,
        A_DONE = 2'd2
    } atomic_states_e;

    function automatic logic [31:0] word_addr(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/atomic_unit_if.sv
// rtl/atomic_unit_if.sv - data memory port used by the atomic unit
// Signals: word address, read enable (data returned next cycle),
// byte write enables, write data, read data.
interface atomic_unit_if;
    logic [31:0] mem_address;
    logic        mem_read_enable;
    logic [3:0]  mem_write_enable;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    modport master (
        output mem_address, mem_read_enable, mem_write_enable, mem_write_data,
        input  mem_read_data
    );

    modport slave (
        input  mem_address, mem_read_enable, mem_write_enable, mem_write_data,
        output mem_read_data
    );
endinterface

// File: rtl/amo_alu.sv
// rtl/amo_alu.sv - combinational AMO new-value computation
// Ports: old_i (memory value), rs2_i (operand), op_i (one-hot sub-op),
// new_o (value to write back). Unknown or non-one-hot sub-ops return old_i.
module amo_alu
    import atomic_unit_pkg::*;
(
    input  logic [31:0]  old_i,
    input  logic [31:0]  rs2_i,
    input  iTypeAtomic_e op_i,
    output logic [31:0]  new_o
);

    always_comb begin
        new_o = old_i;
        case (op_i)
            AMOSWAP_W: new_o = rs2_i;
            AMOADD_W:  new_o = old_i + rs2_i;
            AMOXOR_W:  new_o = old_i ^ rs2_i;
            AMOAND_W:  new_o = old_i & rs2_i;
            AMOOR_W:   new_o = old_i | rs2_i;
            // strict compares so ties keep the old value
            AMOMIN_W:  new_o = ($signed(rs2_i) < $signed(old_i)) ? rs2_i : old_i;
            AMOMAX_W:  new_o = ($signed(rs2_i) > $signed(old_i)) ? rs2_i : old_i;
            AMOMINU_W: new_o = (rs2_i < old_i) ? rs2_i : old_i;
            AMOMAXU_W: new_o = (rs2_i > old_i) ? rs2_i : old_i;
            default:   new_o = old_i;
        endcase
    end

endmodule

// File: rtl/atomic_unit.sv
// rtl/atomic_unit.sv - LR_W / SC_W / AMO_W execute unit with one reservation
// Ports: clk, reset_n (async active-low); valid_i, instruction_operation_i,
// atomic_operation_i, address_i, rs2_data_i (decoded instruction); kill_i;
// store_snoop_i/store_snoop_addr_i (regular store watch); mem (memory port,
// master); hold_o, result_o, result_valid_o, misaligned_o.
// Optional: LRSC_TIMEOUT_EN enables reservation expiry after TIMEOUT_CYCLES.
module atomic_unit
    import atomic_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                valid_i,
    input  iType_e              instruction_operation_i,
    input  iTypeAtomic_e        atomic_operation_i,
    input  logic [31:0]         address_i,
    input  logic [31:0]         rs2_data_i,
    input  logic                kill_i,
    input  logic                store_snoop_i,
    input  logic [31:0]         store_snoop_addr_i,
    atomic_unit_if.master       mem,
    output logic                hold_o,
    output logic [31:0]         result_o,
    output logic                result_valid_o,
    output logic                misaligned_o
);

    atomic_states_e state_q, state_d;
    logic           resv_valid_q, resv_valid_d;
    logic [29:0]    resv_addr_q, resv_addr_d;
    logic [29:0]    addr_q, addr_d;
    logic [31:0]    rs2_q, rs2_d;
    iTypeAtomic_e   amo_op_q, amo_op_d;
    logic           is_amo_q, is_amo_d;
    logic           sc_fail_q, sc_fail_d;
    logic [31:0]    amo_new;
    logic           accept, start, sc_hit, unused_snoop_lsb;

`ifdef LRSC_TIMEOUT_EN
    logic [31:0]    tmo_cnt_q, tmo_cnt_d;
`else
    logic           unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    assign unused_snoop_lsb = ^store_snoop_addr_i[1:0];

    amo_alu u_amo_alu (
        .old_i (mem.mem_read_data),
        .rs2_i (rs2_q),
        .op_i  (amo_op_q),
        .new_o (amo_new)
    );

    always_comb begin
        state_d      = state_q;
        resv_valid_d = resv_valid_q;
        resv_addr_d  = resv_addr_q;
        addr_d       = addr_q;
        rs2_d        = rs2_q;
        amo_op_d     = amo_op_q;
        is_amo_d     = is_amo_q;
        sc_fail_d    = sc_fail_q;
`ifdef LRSC_TIMEOUT_EN
        tmo_cnt_d    = tmo_cnt_q;
`endif
        mem.mem_address      = 32'h0;
        mem.mem_read_enable  = 1'b0;
        mem.mem_write_enable = 4'h0;
        mem.mem_write_data   = 32'h0;
        hold_o               = 1'b0;
        result_o             = 32'h0;
        result_valid_o       = 1'b0;

        accept = (state_q == A_IDLE) && valid_i && !kill_i &&
                 (instruction_operation_i inside {LR_W, SC_W, AMO_W});
        misaligned_o = accept && (address_i[1:0] != 2'b00);
        start  = accept && !misaligned_o;
        sc_hit = resv_valid_q && (resv_addr_q == address_i[31:2]);

        if (store_snoop_i && (store_snoop_addr_i[31:2] == resv_addr_q))
            resv_valid_d = 1'b0;

`ifdef LRSC_TIMEOUT_EN
        if (resv_valid_q) begin
            if (tmo_cnt_q == 32'd0) resv_valid_d = 1'b0;
            else                    tmo_cnt_d = tmo_cnt_q - 32'd1;
        end
`endif

        unique case (state_q)
            A_IDLE: begin
                if (start) begin
                    mem.mem_address = word_addr(address_i);
                    hold_o          = 1'b1;
                    addr_d          = address_i[31:2];
                    if (instruction_operation_i == SC_W) begin
                        if (sc_hit) begin
                            mem.mem_write_enable = 4'hF;
                            mem.mem_write_data   = rs2_data_i;
                        end
                        sc_fail_d    = !sc_hit;
                        resv_valid_d = 1'b0;
                        state_d      = A_DONE;
                    end else begin
                        mem.mem_read_enable = 1'b1;
                        rs2_d    = rs2_data_i;
                        amo_op_d = atomic_operation_i;
                        is_amo_d = (instruction_operation_i == AMO_W);
                        if (is_amo_d && (resv_addr_q == address_i[31:2]))
                            resv_valid_d = 1'b0;
                        state_d  = A_LOAD;
                    end
                end
            end
            A_LOAD: begin
                state_d = A_IDLE;
                if (!kill_i) begin
                    result_o       = mem.mem_read_data;
                    result_valid_o = 1'b1;
                    if (is_amo_q) begin
                        mem.mem_address      = {addr_q, 2'b00};
                        mem.mem_write_enable = 4'hF;
                        mem.mem_write_data   = amo_new;
                    end else begin
                        // LR set overrides a same-cycle snoop clear
                        resv_valid_d = 1'b1;
                        resv_addr_d  = addr_q;
`ifdef LRSC_TIMEOUT_EN
                        tmo_cnt_d    = 32'(TIMEOUT_CYCLES - 1);
`endif
                    end
                end
            end
            A_DONE: begin
                state_d = A_IDLE;
                if (!kill_i) begin
                    result_o       = {31'b0, sc_fail_q};
                    result_valid_o = 1'b1;
                end
            end
            default: state_d = A_IDLE;
        endcase

        if (kill_i) begin
            state_d      = A_IDLE;
            resv_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= A_IDLE;
            resv_valid_q <= 1'b0;
            resv_addr_q  <= 30'h0;
            addr_q       <= 30'h0;
            rs2_q        <= 32'h0;
            amo_op_q     <= AMONOP;
            is_amo_q     <= 1'b0;
            sc_fail_q    <= 1'b0;
`ifdef LRSC_TIMEOUT_EN
            tmo_cnt_q    <= 32'h0;
`endif
        end else begin
            state_q      <= state_d;
            resv_valid_q <= resv_valid_d;
            resv_addr_q  <= resv_addr_d;
            addr_q       <= addr_d;
            rs2_q        <= rs2_d;
            amo_op_q     <= amo_op_d;
            is_amo_q     <= is_amo_d;
            sc_fail_q    <= sc_fail_d;
`ifdef LRSC_TIMEOUT_EN
            tmo_cnt_q    <= tmo_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_atomic_unit.sv
// tb/tb_atomic_unit.sv - scoreboard bench for atomic_unit
module tb_atomic_unit;
    import atomic_unit_pkg::*;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    logic         clk;
    logic         reset_n;
    logic         valid_i;
    iType_e       instr;
    iTypeAtomic_e sub;
    logic [31:0]  address_i;
    logic [31:0]  rs2_data_i;
    logic         kill_i;
    logic         store_snoop_i;
    logic [31:0]  store_snoop_addr_i;
    logic         hold_o;
    logic [31:0]  result_o;
    logic         result_valid_o;
    logic         misaligned_o;

    logic [31:0]  mem [0:255];
    logic [31:0]  rdata_q;
    logic         pl_en;
    logic [31:0]  pl_addr;
    logic [31:0]  pl_data;

    int           checks;
    int           failures;
    int           hold_cnt;
    int           h0;
    int           exp_mis;
    logic [31:0]  exp_res [$];
    wr_t          exp_wr [$];

    atomic_unit_if mif ();

    atomic_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .valid_i                 (valid_i),
        .instruction_operation_i (instr),
        .atomic_operation_i      (sub),
        .address_i               (address_i),
        .rs2_data_i              (rs2_data_i),
        .kill_i                  (kill_i),
        .store_snoop_i           (store_snoop_i),
        .store_snoop_addr_i      (store_snoop_addr_i),
        .mem                     (mif.master),
        .hold_o                  (hold_o),
        .result_o                (result_o),
        .result_valid_o          (result_valid_o),
        .misaligned_o            (misaligned_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign mif.mem_read_data = rdata_q;

    always @(posedge clk) begin
        if (pl_en)
            mem[pl_addr[9:2]] <= pl_data;
        else if (mif.mem_write_enable == 4'hF)
            mem[mif.mem_address[9:2]] <= mif.mem_write_data;
        if (mif.mem_read_enable)
            rdata_q <= mem[mif.mem_address[9:2]];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        checks++;
        failures++;
        $display("FAIL %s actual=%h required=none", name, act);
    endtask

    task automatic monitor();
        wr_t w;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (hold_o) hold_cnt++;
                if (result_valid_o) begin
                    if (exp_res.size() == 0) unexpected("unexpected_result", result_o);
                    else check("result", result_o, exp_res.pop_front());
                end
                if (mif.mem_write_enable != 4'h0) begin
                    if (exp_wr.size() == 0) unexpected("unexpected_write", mif.mem_write_data);
                    else begin
                        w = exp_wr.pop_front();
                        check("wr_addr", mif.mem_address, w.a);
                        check("wr_data", mif.mem_write_data, w.d);
                        check("wr_en", {28'b0, mif.mem_write_enable}, 32'hF);
                    end
                end
                if (misaligned_o) begin
                    if (exp_mis == 0) unexpected("unexpected_misaligned", 32'h1);
                    else begin
                        checks++;
                        exp_mis--;
                    end
                end
            end
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_hold"}, {31'b0, hold_o}, 32'h0);
        check({tag, "_rvalid"}, {31'b0, result_valid_o}, 32'h0);
        check({tag, "_result"}, result_o, 32'h0);
        check({tag, "_mis"}, {31'b0, misaligned_o}, 32'h0);
        check({tag, "_addr"}, mif.mem_address, 32'h0);
        check({tag, "_re"}, {31'b0, mif.mem_read_enable}, 32'h0);
        check({tag, "_we"}, {28'b0, mif.mem_write_enable}, 32'h0);
        check({tag, "_wdata"}, mif.mem_write_data, 32'h0);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        cyc();
        pl_en = 1'b0;
    endtask

    task automatic issue(input iType_e op, input iTypeAtomic_e so, input logic [31:0] a,
                         input logic [31:0] r, input bit snoop1 = 1'b0,
                         input logic [31:0] saddr = 32'h0, input bit kill1 = 1'b0);
        valid_i = 1'b1; instr = op; sub = so; address_i = a; rs2_data_i = r;
        cyc();
        valid_i = 1'b0; instr = NOP; sub = AMONOP;
        store_snoop_i = snoop1; store_snoop_addr_i = saddr; kill_i = kill1;
        cyc();
        store_snoop_i = 1'b0; kill_i = 1'b0;
    endtask

    task automatic amo_case(input iTypeAtomic_e so, input logic [31:0] r, input logic [31:0] newv);
        preload(32'h300, 32'hFFFF_FFFE);
        h0 = hold_cnt;
        exp_res.push_back(32'hFFFF_FFFE);
        exp_wr.push_back('{a: 32'h300, d: newv});
        issue(AMO_W, so, 32'h300, r);
        check("amo_hold_cycles", 32'(hold_cnt - h0), 32'h1);
    endtask

    initial begin
        checks = 0; failures = 0; hold_cnt = 0; exp_mis = 0;
        reset_n = 1'b0; valid_i = 1'b0; instr = NOP; sub = AMONOP;
        address_i = 32'h0; rs2_data_i = 32'h0; kill_i = 1'b0;
        store_snoop_i = 1'b0; store_snoop_addr_i = 32'h0;
        pl_en = 1'b0; pl_addr = 32'h0; pl_data = 32'h0;
        fork
            monitor();
        join_none

        @(negedge clk);
        check_quiet("reset");
        cyc(); cyc();
        reset_n = 1'b1;
        cyc();

        // non-atomic op and killed atomic are both ignored
        valid_i = 1'b1; instr = LOAD_WORD; address_i = 32'h103;
        @(negedge clk);
        check_quiet("non_atomic");
        cyc();
        instr = LR_W; address_i = 32'h100; kill_i = 1'b1;
        @(negedge clk);
        check_quiet("killed_accept");
        cyc();
        valid_i = 1'b0; instr = NOP; kill_i = 1'b0;

        // LR then successful SC
        preload(32'h100, 32'hDEAD_BEEF);
        exp_res.push_back(32'hDEAD_BEEF);
        issue(LR_W, AMONOP, 32'h100, 32'h0);
        exp_wr.push_back('{a: 32'h100, d: 32'h5});
        exp_res.push_back(32'h0);
        issue(SC_W, AMONOP, 32'h100, 32'h5);

        // SC without reservation, then snoop kills a reservation
        exp_res.push_back(32'h1);
        issue(SC_W, AMONOP, 32'h100, 32'h6);
        exp_res.push_back(32'h5);
        issue(LR_W, AMONOP, 32'h100, 32'h0);
        store_snoop_i = 1'b1; store_snoop_addr_i = 32'h102;
        cyc();
        store_snoop_i = 1'b0;
        exp_res.push_back(32'h1);
        issue(SC_W, AMONOP, 32'h100, 32'h7);

        // LR set beats a same-cycle matching snoop
        preload(32'h180, 32'h77);
        exp_res.push_back(32'h77);
        issue(LR_W, AMONOP, 32'h180, 32'h0, 1'b1, 32'h180);
        exp_wr.push_back('{a: 32'h180, d: 32'h9});
        exp_res.push_back(32'h0);
        issue(SC_W, AMONOP, 32'h180, 32'h9);

        // kill while an LR completes: no result, no reservation
        issue(LR_W, AMONOP, 32'h180, 32'h0, 1'b0, 32'h0, 1'b1);
        exp_res.push_back(32'h1);
        issue(SC_W, AMONOP, 32'h180, 32'hA);

        // AMO sweep, old = 0xFFFFFFFE
        amo_case(AMOADD_W,  32'h1, 32'hFFFF_FFFF);
        amo_case(AMOMIN_W,  32'h1, 32'hFFFF_FFFE);
        amo_case(AMOMINU_W, 32'h1, 32'h0000_0001);
        amo_case(AMOMAXU_W, 32'h1, 32'hFFFF_FFFE);
        amo_case(AMOSWAP_W, 32'h1, 32'h0000_0001);
        amo_case(AMOMAX_W,  32'h1, 32'h0000_0001);
        amo_case(AMOXOR_W,  32'h1, 32'hFFFF_FFFF);
        amo_case(AMOAND_W,  32'h1, 32'h0000_0000);
        amo_case(AMOOR_W,   32'h1, 32'hFFFF_FFFF);
        amo_case(AMOMIN_W,  32'hFFFF_FFFE, 32'hFFFF_FFFE);
        amo_case(AMONOP,    32'h1, 32'hFFFF_FFFE);
        amo_case(iTypeAtomic_e'(10'b00_0000_0110), 32'h1, 32'hFFFF_FFFE);

        // AMO to the reserved word clears the reservation
        preload(32'h300, 32'h10);
        exp_res.push_back(32'h10);
        issue(LR_W, AMONOP, 32'h300, 32'h0);
        exp_res.push_back(32'h10);
        exp_wr.push_back('{a: 32'h300, d: 32'h11});
        issue(AMO_W, AMOADD_W, 32'h300, 32'h1);
        exp_res.push_back(32'h1);
        issue(SC_W, AMONOP, 32'h300, 32'h2);

        // misaligned AMO
        exp_mis++;
        valid_i = 1'b1; instr = AMO_W; sub = AMOADD_W; address_i = 32'h103; rs2_data_i = 32'h1;
        @(negedge clk);
        check("mis_flag", {31'b0, misaligned_o}, 32'h1);
        check("mis_re", {31'b0, mif.mem_read_enable}, 32'h0);
        check("mis_we", {28'b0, mif.mem_write_enable}, 32'h0);
        check("mis_hold", {31'b0, hold_o}, 32'h0);
        cyc();
        valid_i = 1'b0; instr = NOP; sub = AMONOP;
        preload(32'h104, 32'h1234);
        exp_res.push_back(32'h1234);
        issue(LR_W, AMONOP, 32'h104, 32'h0);

        // kill during AMO read phase
        preload(32'h200, 32'hCAFE);
        issue(AMO_W, AMOADD_W, 32'h200, 32'h1, 1'b0, 32'h0, 1'b1);
        exp_res.push_back(32'hCAFE);
        issue(LR_W, AMONOP, 32'h200, 32'h0);

        // async reset in the middle of A_LOAD
        exp_res.push_back(32'h5);
        issue(LR_W, AMONOP, 32'h100, 32'h0);
        valid_i = 1'b1; instr = AMO_W; sub = AMOADD_W; address_i = 32'h200; rs2_data_i = 32'h1;
        cyc();
        valid_i = 1'b0; instr = NOP; sub = AMONOP;
        reset_n = 1'b0;
        #1;
        check_quiet("reset_mid");
        cyc();
        reset_n = 1'b1;
        exp_res.push_back(32'h1);
        issue(SC_W, AMONOP, 32'h100, 32'h3);

        // reservation lifetime
        preload(32'h40, 32'h11);
        exp_res.push_back(32'h11);
        issue(LR_W, AMONOP, 32'h40, 32'h0);
        cyc(); cyc();
        exp_wr.push_back('{a: 32'h40, d: 32'hAA});
        exp_res.push_back(32'h0);
        issue(SC_W, AMONOP, 32'h40, 32'hAA);
        exp_res.push_back(32'hAA);
        issue(LR_W, AMONOP, 32'h40, 32'h0);
        repeat (5) cyc();
`ifdef LRSC_TIMEOUT_EN
        exp_res.push_back(32'h1);
`else
        exp_wr.push_back('{a: 32'h40, d: 32'hBB});
        exp_res.push_back(32'h0);
`endif
        issue(SC_W, AMONOP, 32'h40, 32'hBB);

        repeat (3) cyc();
        check("pending_results", 32'(exp_res.size()), 32'h0);
        check("pending_writes", 32'(exp_wr.size()), 32'h0);
        check("pending_misaligned", 32'(exp_mis), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
